// File: rtl/fetch_pkg.sv
// fetch_pkg: PC-select encodings, fetch FSM states and default multi-cycle
// latencies shared by the fetch control logic.
package fetch_pkg;

   typedef enum logic [1:0] {
      PC_INC  = 2'b00,
      PC_DEC  = 2'b01,
      PC_ALU  = 2'b10,
      PC_HOLD = 2'b11
   } pc_sel_t;

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      MD_WAIT  = 2'b01,
      ACC_WAIT = 2'b10,
      HALT     = 2'b11
   } state_t;

   localparam int MUL_CYCLES_DEF = 2;
   localparam int DIV_CYCLES_DEF = 33;

endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC mux select, pipeline enable/flush and stall accounting for
// redirects, multi-cycle M-extension ops, accelerator back-pressure and halt.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int MUL_CYCLES = MUL_CYCLES_DEF,
   parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        jump_dec,
   input  logic        branch_alu,
   input  logic        md_start,
   input  logic        md_is_div,
   input  logic        acc_busy,
   input  logic        halt_req,
   input  logic        resume,
   output logic [1:0]  pc_s,
   output logic        pc_en,
   output logic        if_id_en,
   output logic        if_id_flush,
   output logic        id_ex_flush,
   output logic [15:0] stall_cnt
);

   localparam logic [5:0] MUL_LD = 6'(MUL_CYCLES - 1);
   localparam logic [5:0] DIV_LD = 6'(DIV_CYCLES - 1);

   state_t     state, nxt;
   logic [5:0] cnt, cnt_nxt, ld;

   assign ld = md_is_div ? DIV_LD : MUL_LD;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= RUN;
         cnt       <= '0;
         stall_cnt <= '0;
      end else begin
         state     <= nxt;
         cnt       <= cnt_nxt;
         stall_cnt <= (state != RUN && stall_cnt != 16'hFFFF) ? stall_cnt + 16'd1 : stall_cnt;
      end
   end

   always_comb begin
      nxt         = state;
      cnt_nxt     = cnt;
      pc_s        = PC_INC;
      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      if (!rst) begin
         pc_s        = PC_HOLD;
         pc_en       = 1'b0;
         if_id_en    = 1'b0;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (state == RUN) begin
         if (halt_req) begin
            nxt     = HALT;
            cnt_nxt = '0;
         end else if (branch_alu) begin
            pc_s        = PC_ALU;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
         end else if (md_start) begin
            cnt_nxt = ld;
            nxt     = (ld != '0) ? MD_WAIT : RUN;
         end else if (acc_busy) begin
            nxt = ACC_WAIT;
         end else if (jump_dec) begin
            pc_s        = PC_DEC;
            if_id_flush = 1'b1;
         end
      end else begin
         pc_s        = PC_HOLD;
         pc_en       = 1'b0;
         if_id_en    = 1'b0;
         id_ex_flush = 1'b1;
         // the wait ends on the edge where the counter reaches zero
         case (state)
            MD_WAIT: begin
               cnt_nxt = (cnt != '0) ? cnt - 6'd1 : cnt;
               nxt     = (cnt <= 6'd1) ? RUN : MD_WAIT;
            end
            ACC_WAIT: nxt = acc_busy ? ACC_WAIT : RUN;
            default:  nxt = resume ? RUN : HALT;
         endcase
         if (halt_req && state != HALT) begin
            nxt     = HALT;
            cnt_nxt = '0;
         end
      end
   end

endmodule
